morse_rx: RTL



---
 rtl/morse_rx_if.sv | 21 ++
 rtl/morse_rx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/morse_rx_if.sv
// Signal bundle between the Morse receiver and whatever drives or observes it.
// Unit timing comes in with the serial stream; decoded letters go out.
interface morse_rx_if;
    logic       unit_tick;
    logic       din;
    logic [2:0] letter;
    logic       letter_valid;
    logic       letter_err;
    logic [2:0] sym_count;
    logic       busy;

    modport master (
        output unit_tick, din,
        input  letter, letter_valid, letter_err, sym_count, busy
    );

    modport slave (
        input  unit_tick, din,
        output letter, letter_valid, letter_err, sym_count, busy
    );
endinterface

// File: rtl/morse_rx.sv
// Serial Morse receiver: samples the encoder's LED line once per unit, splits
// marks into dots/dashes and decodes each letter back to the 3-bit switch code.
module morse_rx #(
    parameter int DASH_UNITS = 3,
    parameter int GAP_UNITS  = 3,
    parameter int MAX_SYMS   = 4
) (
    input  logic     clock,
    input  logic     reset,
    morse_rx_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

    localparam logic [2:0] DASH_RUN  = 3'(DASH_UNITS);
    localparam logic [2:0] GAP_RUN   = 3'(GAP_UNITS);
    localparam logic [2:0] MAX_COUNT = 3'(MAX_SYMS);

    // First symbol received ends up in the most significant used bit.
    localparam logic [MAX_SYMS-1:0] PAT_J = MAX_SYMS'(4'b0111);
    localparam logic [MAX_SYMS-1:0] PAT_K = MAX_SYMS'(3'b101);
    localparam logic [MAX_SYMS-1:0] PAT_L = MAX_SYMS'(4'b0100);
    localparam logic [MAX_SYMS-1:0] PAT_M = MAX_SYMS'(2'b11);
    localparam logic [MAX_SYMS-1:0] PAT_N = MAX_SYMS'(2'b10);
    localparam logic [MAX_SYMS-1:0] PAT_O = MAX_SYMS'(3'b111);
    localparam logic [MAX_SYMS-1:0] PAT_P = MAX_SYMS'(4'b0110);
    localparam logic [MAX_SYMS-1:0] PAT_Q = MAX_SYMS'(4'b1101);

    state_t              state, state_next;
    logic [2:0]          run, run_next, run_inc;
    logic [MAX_SYMS-1:0] syms, syms_next;
    logic [2:0]          sym_count, sym_count_next;
    logic                err_flag, err_next;
    logic                emit;
    logic [2:0]          letter_dec;
    logic                dec_miss;
    logic [2:0]          letter;
    logic                letter_valid;
    logic                letter_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            run       <= 3'd0;
            syms      <= '0;
            sym_count <= 3'd0;
            err_flag  <= 1'b0;
        end else if (bus.unit_tick) begin
            state     <= state_next;
            run       <= run_next;
            syms      <= syms_next;
            sym_count <= sym_count_next;
            err_flag  <= err_next;
        end
    end

    always_comb begin
        run_inc        = (run == 3'd7) ? run : run + 3'd1;
        state_next     = state;
        run_next       = run;
        syms_next      = syms;
        sym_count_next = sym_count;
        err_next       = err_flag;
        emit           = 1'b0;
        case (state)
            IDLE: begin
                if (bus.din) begin
                    state_next     = MARK;
                    run_next       = 3'd1;
                    syms_next      = '0;
                    sym_count_next = 3'd0;
                    err_next       = 1'b0;
                end
            end
            MARK: begin
                if (bus.din) begin
                    run_next = run_inc;
                end else begin
                    // Odd-length marks still occupy a slot so the symbol count stays honest.
                    if (sym_count == MAX_COUNT) begin
                        err_next = 1'b1;
                    end else begin
                        syms_next      = {syms[MAX_SYMS-2:0], (run == DASH_RUN)};
                        sym_count_next = sym_count + 3'd1;
                        if (run != 3'd1 && run != DASH_RUN) begin
                            err_next = 1'b1;
                        end
                    end
                    state_next = SPACE;
                    run_next   = 3'd1;
                end
            end
            SPACE: begin
                if (bus.din) begin
                    if (run != 3'd1) begin
                        err_next = 1'b1;
                    end
                    state_next = MARK;
                    run_next   = 3'd1;
                end else begin
                    run_next = run_inc;
                    if (run_inc == GAP_RUN) begin
                        emit       = bus.unit_tick;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        letter_dec = 3'b000;
        dec_miss   = 1'b0;
        case (sym_count)
            3'd2: begin
                if      (syms == PAT_M) letter_dec = 3'b100;
                else if (syms == PAT_N) letter_dec = 3'b101;
                else                    dec_miss   = 1'b1;
            end
            3'd3: begin
                if      (syms == PAT_K) letter_dec = 3'b010;
                else if (syms == PAT_O) letter_dec = 3'b110;
                else                    dec_miss   = 1'b1;
            end
            3'd4: begin
                if      (syms == PAT_J) letter_dec = 3'b001;
                else if (syms == PAT_L) letter_dec = 3'b011;
                else if (syms == PAT_P) letter_dec = 3'b111;
                else if (syms == PAT_Q) letter_dec = 3'b000;
                else                    dec_miss   = 1'b1;
            end
            default: dec_miss = 1'b1;
        endcase
    end

    // The valid pulse is not gated by unit_tick so it always lasts exactly one clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            letter       <= 3'b000;
            letter_valid <= 1'b0;
            letter_err   <= 1'b0;
        end else begin
            letter_valid <= emit;
            if (emit) begin
                letter_err <= err_flag | dec_miss;
                letter     <= (err_flag | dec_miss) ? 3'b000 : letter_dec;
            end
        end
    end

    assign bus.letter       = letter;
    assign bus.letter_valid = letter_valid;
    assign bus.letter_err   = letter_err;
    assign bus.sym_count    = sym_count;
    assign bus.busy         = (state != IDLE);

endmodule
